conv3x3_engine: RTL
===================

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 256: pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 256: lines per frame.
REQ-003 SHALL have parameter SHIFT, default 7: requantization right-shift amount, range 0..15.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports p1..p9  input  8 each  unsigned 3x3 window pixels, row-major, p1 = oldest row and oldest column, p9 = newest pixel.
REQ-007 SHALL have port stall  input  1  high means the window is invalid this cycle.
REQ-008 SHALL have port cfg_start  input  1  single-cycle pulse that starts a weight load.
REQ-009 SHALL have port bias_in  input  16  signed bias, captured on cfg_start.
REQ-010 SHALL have port wt_valid  input  1  weight word strobe.
REQ-011 SHALL have port wt_data  input  8  signed weight, w1..w9 in order.
REQ-012 SHALL have port cfg_busy  output  1  high while in LOAD.
REQ-013 SHALL have port pix_out  output  8  unsigned result pixel.
REQ-014 SHALL have port pix_valid  output  1  pix_out qualifier.
REQ-015 SHALL have port frame_done  output  1  single-cycle pulse marking the last output of a frame.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD and RUN; reset state is IDLE.
REQ-017 SHALL go from IDLE or RUN to LOAD on cfg_start, capturing bias_in and clearing the weight index to 0.
REQ-018 SHALL, in LOAD, write wt_data to w[index] and increment the index on each wt_valid; wt_valid with index 8 SHALL go to RUN on the next cycle.
REQ-019 SHALL ignore wt_valid outside LOAD; cfg_start during LOAD SHALL restart the load at index 0.
REQ-020 SHALL accept a window only in RUN with stall=0; in IDLE and LOAD no window is accepted.
REQ-021 SHALL, per product, form pixel (zero-extended) x weight as signed 17-bit.
REQ-022 SHALL form acc = sum of 9 products + bias, signed 22-bit, with no overflow possible.
REQ-023 SHALL compute y = acc arithmetic-shifted right by SHIFT, then set pix_out = 0 if y<0, 255 if y>255, else y[7:0] (ReLU plus saturation).
REQ-024 SHALL use a 4-stage pipeline, each stage with its own valid bit:
- S1 registers the 9 products.
- S2 registers 3 row sums.
- S3 registers the total plus bias.
- S4 registers the shifted and clamped result.
REQ-025 SHALL give a latency of exactly 4 cycles from an accepted window to pix_valid=1; throughput one window per cycle.
REQ-026 SHALL count pix_valid outputs; when the count reaches (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2), frame_done SHALL pulse in the same cycle as that pix_valid, and the counter SHALL wrap to 0.
REQ-027 SHALL, on entry to LOAD, clear all pipeline valid bits and the output counter, so in-flight results are dropped and pix_valid=0 during LOAD.
REQ-028 SHALL hold pix_out at its last value when pix_valid=0.

Reset
REQ-029 SHALL, on rst_n low, immediately clear state to IDLE, weights, bias, index, counter, all pipeline data and valids, pix_out, pix_valid, frame_done and cfg_busy to 0.
REQ-030 SHALL, on reset mid-frame or mid-load, discard all partial results and require a full reload after release.

Structure
REQ-031 SHALL place the FSM state encoding, PIX_W=8, WT_W=8, PROD_W=17 and ACC_W=22 in shared package conv_pkg.
REQ-032 SHALL use one sub-module, conv_row3, which takes 3 pixels and 3 weights and produces a registered 3-product row sum covering S1 and S2; it SHALL be instantiated three times.

Verification
REQ-033 SHALL cover: weights all 1, bias 0, SHIFT=0, all pixels 10, stall=0 -> pix_out=90, pix_valid 4 cycles after the first accepted window.
REQ-034 SHALL cover: w5=1, others 0, SHIFT=0, pixel ramp on p5 -> pix_out equals p5 delayed 4 cycles.
REQ-035 SHALL cover: weights all -1 with pixels 200 -> pix_out=0; weights all 127 with pixels 255, SHIFT=0 -> pix_out=255.
REQ-036 SHALL cover: random stall pattern in RUN -> pix_valid equals ~stall delayed exactly 4 cycles.
REQ-037 SHALL cover: IMAGE_WIDTH=8, IMAGE_HEIGHT=8, full-frame stall pattern -> 36 outputs, frame_done only with the 36th, counter back to 0.
REQ-038 SHALL cover: cfg_start 2 cycles after window acceptance in RUN -> no pix_valid for the in-flight windows; cfg_busy=1 until the 9th weight is loaded.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and the output clamp used by the 3x3 convolution engine.
// Every module of the engine imports this package.
package conv_pkg;

    localparam int PIX_W    = 8;
    localparam int WT_W     = 8;
    localparam int PROD_W   = 17;
    localparam int ACC_W    = 22;
    localparam int BIAS_W   = 16;
    localparam int ROW_W    = PROD_W + 2;
    localparam int NUM_TAPS = 9;
    localparam int IDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } conv_state_e;

    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

    // ReLU followed by saturation to the unsigned 8-bit pixel range.
    function automatic logic [PIX_W-1:0] clampPixel(input logic signed [ACC_W-1:0] y);
        logic [PIX_W-1:0] result;
        if (y[ACC_W-1]) begin
            result = '0;
        end else if (y > PIX_MAX) begin
            result = '1;
        end else begin
            result = y[PIX_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_row3.sv
// One kernel row: three pixel x weight products registered (S1), then their sum
// registered (S2). Valid tracking lives in the parent.
module conv_row3
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIX_W-1:0]         i_pix0,
    input  logic [PIX_W-1:0]         i_pix1,
    input  logic [PIX_W-1:0]         i_pix2,
    input  logic signed [WT_W-1:0]   i_wt0,
    input  logic signed [WT_W-1:0]   i_wt1,
    input  logic signed [WT_W-1:0]   i_wt2,
    output logic signed [ROW_W-1:0]  o_rowSum
);

    logic signed [PROD_W-1:0] w_prod0;
    logic signed [PROD_W-1:0] w_prod1;
    logic signed [PROD_W-1:0] w_prod2;
    logic signed [PROD_W-1:0] r_prod0;
    logic signed [PROD_W-1:0] r_prod1;
    logic signed [PROD_W-1:0] r_prod2;
    logic signed [ROW_W-1:0]  r_rowSum;

    // Pixels are zero-extended so they stay non-negative in the signed multiply.
    assign w_prod0 = PROD_W'($signed({1'b0, i_pix0})) * PROD_W'(i_wt0);
    assign w_prod1 = PROD_W'($signed({1'b0, i_pix1})) * PROD_W'(i_wt1);
    assign w_prod2 = PROD_W'($signed({1'b0, i_pix2})) * PROD_W'(i_wt2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod0  <= '0;
            r_prod1  <= '0;
            r_prod2  <= '0;
            r_rowSum <= '0;
        end else begin
            r_prod0  <= w_prod0;
            r_prod1  <= w_prod1;
            r_prod2  <= w_prod2;
            r_rowSum <= ROW_W'(r_prod0) + ROW_W'(r_prod1) + ROW_W'(r_prod2);
        end
    end

    assign o_rowSum = r_rowSum;

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: loadable signed weights and bias, 4-stage pipeline,
// requantization with ReLU and saturation, and end-of-frame signalling.
module conv3x3_engine
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = 256,
    parameter int SHIFT        = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIX_W-1:0]         p1,
    input  logic [PIX_W-1:0]         p2,
    input  logic [PIX_W-1:0]         p3,
    input  logic [PIX_W-1:0]         p4,
    input  logic [PIX_W-1:0]         p5,
    input  logic [PIX_W-1:0]         p6,
    input  logic [PIX_W-1:0]         p7,
    input  logic [PIX_W-1:0]         p8,
    input  logic [PIX_W-1:0]         p9,
    input  logic                     stall,
    input  logic                     cfg_start,
    input  logic signed [BIAS_W-1:0] bias_in,
    input  logic                     wt_valid,
    input  logic signed [WT_W-1:0]   wt_data,
    output logic                     cfg_busy,
    output logic [PIX_W-1:0]         pix_out,
    output logic                     pix_valid,
    output logic                     frame_done
);

    localparam int FRAME_PIX = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);
    localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIX - 1);
    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

    conv_state_e               r_state;
    conv_state_e               w_nextState;
    logic                      w_accept;
    logic                      w_wtWrite;
    logic signed [WT_W-1:0]    r_wt [NUM_TAPS];
    logic signed [BIAS_W-1:0]  r_bias;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_v1;
    logic                      r_v2;
    logic                      r_v3;
    logic                      r_v4;
    logic signed [ROW_W-1:0]   w_rowSum0;
    logic signed [ROW_W-1:0]   w_rowSum1;
    logic signed [ROW_W-1:0]   w_rowSum2;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   w_shifted;
    logic [PIX_W-1:0]          r_pixOut;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_frameDone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // cfg_start wins in every state, so a load can always be restarted from scratch.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_wtWrite   = 1'b0;
        cfg_busy    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                cfg_busy = 1'b1;
                if (cfg_start) begin
                    w_nextState = LOAD;
                end else if (wt_valid) begin
                    w_wtWrite = 1'b1;
                    if (r_idx == LAST_TAP) begin
                        w_nextState = RUN;
                    end
                end
            end
            RUN: begin
                if (cfg_start) begin
                    w_nextState = LOAD;
                end else begin
                    w_accept = ~stall;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_wt[k] <= '0;
            end
            r_bias <= '0;
            r_idx  <= '0;
        end else if (cfg_start) begin
            r_bias <= bias_in;
            r_idx  <= '0;
        end else if (w_wtWrite) begin
            r_wt[r_idx] <= wt_data;
            r_idx       <= r_idx + 1'b1;
        end
    end

    conv_row3 u_row0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pix0   (p1),
        .i_pix1   (p2),
        .i_pix2   (p3),
        .i_wt0    (r_wt[0]),
        .i_wt1    (r_wt[1]),
        .i_wt2    (r_wt[2]),
        .o_rowSum (w_rowSum0)
    );

    conv_row3 u_row1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pix0   (p4),
        .i_pix1   (p5),
        .i_pix2   (p6),
        .i_wt0    (r_wt[3]),
        .i_wt1    (r_wt[4]),
        .i_wt2    (r_wt[5]),
        .o_rowSum (w_rowSum1)
    );

    conv_row3 u_row2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pix0   (p7),
        .i_pix1   (p8),
        .i_pix2   (p9),
        .i_wt0    (r_wt[6]),
        .i_wt1    (r_wt[7]),
        .i_wt2    (r_wt[8]),
        .o_rowSum (w_rowSum2)
    );

    // Starting a load flushes everything in flight, including the window accepted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_v4 <= 1'b0;
        end else if (cfg_start) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_v4 <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= ACC_W'(w_rowSum0) + ACC_W'(w_rowSum1) + ACC_W'(w_rowSum2) + ACC_W'(r_bias);
        end
    end

    assign w_shifted = r_acc >>> SHIFT;

    // The output register only moves on a real result so pix_out holds between outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixOut    <= '0;
            r_cnt       <= '0;
            r_frameDone <= 1'b0;
        end else if (cfg_start) begin
            r_cnt       <= '0;
            r_frameDone <= 1'b0;
        end else if (r_v3) begin
            r_pixOut    <= clampPixel(w_shifted);
            r_frameDone <= (r_cnt == CNT_LAST);
            r_cnt       <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        end else begin
            r_frameDone <= 1'b0;
        end
    end

    assign pix_out    = r_pixOut;
    assign pix_valid  = r_v4;
    assign frame_done = r_frameDone;

endmodule
